// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Also holds the misalignment classifier used when DMEM_MISALIGN_CHECK_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEPTH_WORDS_DEF = 256;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_BYTE  = 4'b0001;

    // Full word off a word boundary, or an adjacent byte pair starting on an odd byte.
    function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] addr_lo);
        logic pair_s;
        pair_s = (be == BE_HALF0) || (be == 4'b0110) || (be == BE_HALF1);
        return ((be == BE_WORD) && (addr_lo != 2'b00)) || (pair_s && addr_lo[0]);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte-lane synchronous write and registered synchronous read.
// Contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IW          = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Lane-masked write or word read; only one happens per access.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end else if (en) begin
            rdata <= mem_r[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: IDLE -> WAIT -> RESP handshake FSM.
// Optional misalignment rejection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    localparam bit         DIRECT    = (WAIT_CYCLES == 0);

    state_e      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  be_r;
    logic        we_r;
    logic        req_ready_r, rsp_valid_r, rsp_err_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_valid_nxt_s, rsp_err_nxt_s;
    logic [31:0] rsp_rdata_nxt_s;

    logic        accept_s, wait_done_s, access_s;
    logic [31:0] acc_addr_s, acc_wdata_s, arr_rdata_s;
    logic [3:0]  acc_be_s;
    logic        acc_we_s, acc_err_s, rsp_err_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    assign accept_s    = req_valid && req_ready_r;
    assign wait_done_s = (state_r == ST_WAIT) && (cnt_r == WAIT_LAST);
    // With no wait states the array is hit on the acceptance edge, before the latches fill.
    assign access_s    = DIRECT ? accept_s : wait_done_s;
    assign acc_addr_s  = DIRECT ? req_addr  : addr_r;
    assign acc_wdata_s = DIRECT ? req_wdata : wdata_r;
    assign acc_be_s    = DIRECT ? req_be    : be_r;
    assign acc_we_s    = DIRECT ? req_we    : we_r;

    // Rejection of the access being committed and of the access being answered.
    always_comb begin
        acc_err_s = ({2'b00, acc_addr_s[31:2]} >= 32'(DEPTH_WORDS));
        rsp_err_s = ({2'b00, addr_r[31:2]} >= 32'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_CHECK_EN
        acc_err_s = acc_err_s | is_misaligned(acc_be_s, acc_addr_s[1:0]);
        rsp_err_s = rsp_err_s | is_misaligned(be_r, addr_r[1:0]);
`endif
    end

`ifndef DMEM_MISALIGN_CHECK_EN
    logic unused_addr_lo_s;
    assign unused_addr_lo_s = ^{acc_addr_s[1:0], addr_r[1:0]};
`endif

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IW          (IW)
    ) u_array (
        .clk   (clk),
        .en    (access_s && !acc_err_s),
        .we    (acc_we_s),
        .be    (acc_be_s),
        .idx   (acc_addr_s[IW+1:2]),
        .wdata (acc_wdata_s),
        .rdata (arr_rdata_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = DIRECT ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and counter next values; the response forms one cycle after the array read.
    always_comb begin
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
        if ((state_r == ST_RESP) && !rsp_valid_r) begin
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = rsp_err_s;
            rsp_rdata_nxt_s = (we_r || rsp_err_s) ? 32'h0000_0000 : arr_rdata_s;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_nxt_s = 1'b0;
            rsp_err_nxt_s   = 1'b0;
            rsp_rdata_nxt_s = 32'h0000_0000;
        end else begin
            rsp_valid_nxt_s = rsp_valid_r;
        end
        if ((state_r == ST_WAIT) && (cnt_r != WAIT_LAST)) begin
            cnt_nxt_s = cnt_r + 4'd1;
        end else begin
            cnt_nxt_s = 4'd0;
        end
    end

    // Output, counter and request-latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            cnt_r       <= 4'd0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'b0000;
            we_r        <= 1'b0;
        end else begin
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            cnt_r       <= cnt_nxt_s;
            if (accept_s) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                be_r    <= req_be;
                we_r    <= req_we;
            end else begin
                addr_r  <= addr_r;
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH_WORDS, 256, number of 32-bit words stored.
- WAIT_CYCLES, 1, wait states between request acceptance and data-array access (0..15).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, requester presents an access.
- req_ready, out, 1, responder can accept an access.
- req_we, in, 1, 1 = store, 0 = load.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, lane-aligned.
- req_be, in, 4, byte enables; bit i selects byte lane i.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, requester takes the response.
- rsp_rdata, out, 32, load data (full word), 0 for stores and errors.
- rsp_err, out, 1, access rejected.

REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; an access is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-006 On acceptance, the block SHALL latch addr, we, wdata and be; it then moves to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-007 WAIT SHALL count WAIT_CYCLES edges and then move to RESP.
REQ-008 rsp_valid SHALL first assert WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-009 The array access (store commit or load capture) SHALL occur on the edge entering RESP.
REQ-010 The word index SHALL be addr[31:2].
REQ-011 If the word index is >= DEPTH_WORDS, the block SHALL set rsp_err=1, perform no write, and return rsp_rdata=0.
REQ-012 A store SHALL write only the lanes whose be bit is 1; be=4'b0000 changes nothing but still completes with rsp_err=0.
REQ-013 A load SHALL return the whole addressed word regardless of be; lane extraction and sign extension belong to the requester.
REQ-014 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_ready=1.
REQ-015 On the edge with rsp_valid=1 and rsp_ready=1, the FSM SHALL return to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
REQ-016 The block SHALL hold at most one outstanding access; req_valid asserted outside IDLE SHALL be ignored until IDLE.
REQ-017 A store followed immediately by a load to the same word SHALL return the newly written data.
REQ-018 Array contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-019 While rst_n=0, the outputs SHALL be: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
REQ-020 A reset asserted in WAIT SHALL discard the access with no array write; a reset in RESP SHALL drop the pending response.

Configuration
REQ-021 With DMEM_MISALIGN_CHECK_EN defined, the block SHALL flag these accesses as misaligned:
- be=4'b1111 with addr[1:0]!=0;
- exactly two contiguous be bits with addr[0]=1.
REQ-022 Misaligned accesses SHALL complete with rsp_err=1, no write, rsp_rdata=0, and the same latency as any other access.
REQ-023 Without DMEM_MISALIGN_CHECK_EN, addr[1:0] SHALL be ignored and no misalignment error SHALL exist.

Structure
REQ-024 Package dmem_pkg SHALL hold the state enum, the DEPTH_WORDS default, and the BE_WORD/BE_HALF0/BE_HALF1/BE_BYTE constants.
REQ-025 Sub-module dmem_array SHALL implement the storage with a synchronous per-lane byte write and a synchronous read; dmem_responder holds the FSM, counter and response registers.

Verification
REQ-026 WAIT_CYCLES=1: store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load 0x10 -> load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-027 Word 4 holds 0xDEADBEEF; store be=4'b0010, wdata=0x0000AA00; load 0x10 -> 0xDEADAAEF.
REQ-028 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable, req_ready=0, and a concurrent req_valid is not accepted.
REQ-029 Load addr=0x400 with DEPTH_WORDS=256 -> rsp_err=1, rsp_rdata=0; a store to 0x400 leaves the array unchanged.
REQ-030 Assert rst_n=0 during WAIT of a store to 0x20 -> no rsp_valid; a subsequent load of 0x20 returns its prior value; outputs match REQ-019.
REQ-031 With DMEM_MISALIGN_CHECK_EN, store be=4'hF to addr=0x12 -> rsp_err=1 and no write; without the macro -> word 4 written, rsp_err=0.
